// File: rtl/cpu_sequencer_pkg.sv
// cpu_sequencer_pkg: shared definitions for the simple 4-bit-PC / 8-bit-instruction CPU.
// Holds widths, opcode encodings, sequencer state encodings and instruction field
// positions. The register file and ALU reuse the same opcode and field definitions.
package cpu_sequencer_pkg;

    localparam int unsigned CPU_PC_W    = 4;
    localparam int unsigned CPU_INSTR_W = 8;

    // Opcodes in IR[7:6]
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_HLT = 2'b10;
    localparam logic [1:0] OP_BZ  = 2'b11;

    // Instruction field bit positions (layout fixed for 8-bit instructions)
    localparam int unsigned OPC_MSB = 7;
    localparam int unsigned OPC_LSB = 6;
    localparam int unsigned RS_MSB  = 5;
    localparam int unsigned RS_LSB  = 4;
    localparam int unsigned RT_MSB  = 3;
    localparam int unsigned RT_LSB  = 2;
    localparam int unsigned RD_MSB  = 1;
    localparam int unsigned RD_LSB  = 0;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExec   = 3'd3,
        StWb     = 3'd4,
        StHalt   = 3'd5
    } state_t;

    function automatic logic [1:0] get_opcode(input logic [CPU_INSTR_W-1:0] ir);
        return ir[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/cpu_pc_counter.sv
// cpu_pc_counter: program counter register with clear, load and wrapping increment.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset (pc -> 0)
//   i_clr      - synchronous clear to 0 (highest priority)
//   i_load     - load i_target
//   i_target   - branch target
//   i_inc      - increment by one, wrapping at 2**W
//   o_pc       - current program counter
module cpu_pc_counter #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic [W-1:0] i_target,
    input  logic         i_inc,
    output logic [W-1:0] o_pc
);

    logic [W-1:0] r_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= '0;
        end else if (i_clr) begin
            r_pc <= '0;
        end else if (i_load) begin
            r_pc <= i_target;
        end else if (i_inc) begin
            r_pc <= r_pc + W'(1);  // natural wrap, no carry out
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle control sequencer for the simple CPU.
// Owns the PC (via cpu_pc_counter) and the instruction register, and steps each
// instruction through FETCH, DECODE, EXEC and (for ADD/SUB) WB.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   start             - begin execution at PC 0 (honoured only in IDLE or HALT)
//   imem_addr/data    - asynchronous-read instruction memory interface
//   rs_zero           - register file port A read data is zero (BZ condition)
//   rf_ra/rf_rb/rf_wa - register file addresses decoded from IR
//   rf_we             - register write enable, high in WB only
//   alu_op            - 0 add, 1 subtract (IR[6])
//   pc                - current program counter
//   busy/halted       - status flags
//   retire            - one-cycle pulse per completed instruction
module cpu_sequencer
    import cpu_sequencer_pkg::*;
#(
    parameter int unsigned PC_W    = CPU_PC_W,
    parameter int unsigned INSTR_W = CPU_INSTR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               rs_zero,
    output logic [1:0]         rf_ra,
    output logic [1:0]         rf_rb,
    output logic [1:0]         rf_wa,
    output logic               rf_we,
    output logic               alu_op,
    output logic [PC_W-1:0]    pc,
    output logic               busy,
    output logic               halted,
    output logic               retire
);

    state_t             r_state;
    logic [INSTR_W-1:0] r_ir;
    logic               r_busy;
    logic               r_halted;
    logic               r_rf_we;

    logic [1:0]         w_opcode;
    logic               w_pc_clr;
    logic               w_pc_load;
    logic               w_pc_inc;
    logic [PC_W-1:0]    w_pc;

    assign w_opcode = get_opcode(r_ir);

    // Sequencer FSM; status outputs are registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= StIdle;
            r_ir     <= '0;
            r_busy   <= 1'b0;
            r_halted <= 1'b0;
            r_rf_we  <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (start) begin
                        r_state <= StFetch;
                        r_busy  <= 1'b1;
                    end
                end
                StFetch: begin
                    r_ir    <= imem_data;
                    r_state <= StDecode;
                end
                StDecode: begin
                    r_state <= StExec;
                end
                StExec: begin
                    case (w_opcode)
                        OP_ADD, OP_SUB: begin
                            r_state <= StWb;
                            r_rf_we <= 1'b1;
                        end
                        OP_BZ: begin
                            r_state <= StFetch;
                        end
                        default: begin  // OP_HLT
                            r_state  <= StHalt;
                            r_busy   <= 1'b0;
                            r_halted <= 1'b1;
                        end
                    endcase
                end
                StWb: begin
                    r_rf_we <= 1'b0;
                    r_state <= StFetch;
                end
                StHalt: begin
                    if (start) begin
                        r_state  <= StFetch;
                        r_busy   <= 1'b1;
                        r_halted <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= StIdle;
                    r_busy   <= 1'b0;
                    r_halted <= 1'b0;
                    r_rf_we  <= 1'b0;
                end
            endcase
        end
    end

    // PC control: restart clears, taken BZ loads, untaken BZ and WB step.
    always_comb begin
        w_pc_clr  = 1'b0;
        w_pc_load = 1'b0;
        w_pc_inc  = 1'b0;
        if ((r_state == StIdle || r_state == StHalt) && start) begin
            w_pc_clr = 1'b1;
        end
        if (r_state == StExec && w_opcode == OP_BZ) begin
            w_pc_load = rs_zero;
            w_pc_inc  = !rs_zero;
        end
        if (r_state == StWb) begin
            w_pc_inc = 1'b1;
        end
    end

    // Completion is visible in the final cycle of each instruction.
    always_comb begin
        retire = 1'b0;
        if (r_state == StWb) begin
            retire = 1'b1;
        end else if (r_state == StExec && (w_opcode == OP_BZ || w_opcode == OP_HLT)) begin
            retire = 1'b1;
        end
    end

    cpu_pc_counter #(
        .W(PC_W)
    ) u_pc (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_pc_clr),
        .i_load   (w_pc_load),
        .i_target (r_ir[PC_W-1:0]),
        .i_inc    (w_pc_inc),
        .o_pc     (w_pc)
    );

    assign pc        = w_pc;
    assign imem_addr = w_pc;
    assign rf_ra     = r_ir[RS_MSB:RS_LSB];
    assign rf_rb     = r_ir[RT_MSB:RT_LSB];
    assign rf_wa     = r_ir[RD_MSB:RD_LSB];
    assign alu_op    = r_ir[OPC_LSB];
    assign rf_we     = r_rf_we;
    assign busy      = r_busy;
    assign halted    = r_halted;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer with a small instruction memory model.
module tb_cpu_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] imem_addr;
    logic [7:0] imem_data;
    logic       rs_zero;
    logic [1:0] rf_ra;
    logic [1:0] rf_rb;
    logic [1:0] rf_wa;
    logic       rf_we;
    logic       alu_op;
    logic [3:0] pc;
    logic       busy;
    logic       halted;
    logic       retire;

    logic [7:0] mem [16];
    int         n_checks;
    int         n_fail;

    assign imem_data = mem[imem_addr];

    cpu_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .rs_zero   (rs_zero),
        .rf_ra     (rf_ra),
        .rf_rb     (rf_rb),
        .rf_wa     (rf_wa),
        .rf_we     (rf_we),
        .alu_op    (alu_op),
        .pc        (pc),
        .busy      (busy),
        .halted    (halted),
        .retire    (retire)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        mem[0]  = 8'b00000110;  // ADD r2 = r0 + r1
        mem[1]  = 8'b01111000;  // SUB r0 = r3 - r2
        mem[2]  = 8'b11001111;  // BZ r0 -> 15
        mem[3]  = 8'b10000000;  // HLT
        mem[15] = 8'b00000111;  // ADD r3 = r0 + r1
        rst     = 1'b1;
        start   = 1'b0;
        rs_zero = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check("rst_pc", pc, 0);
        check("rst_busy", busy, 0);
        check("rst_halted", halted, 0);
        check("rst_retire", retire, 0);
        check("rst_rf_we", rf_we, 0);
        check("rst_rf_wa", rf_wa, 0);
        check("rst_alu_op", alu_op, 0);
        for (int i = 0; i < 10; i++) begin
            step();
            check("idle_busy", busy, 0);
            check("idle_rf_we", rf_we, 0);
            check("idle_addr", imem_addr, 0);
        end

        // ADD at pc 0
        start = 1'b1;
        step();
        start = 1'b0;
        check("add_fetch_busy", busy, 1);
        check("add_fetch_pc", pc, 0);
        check("add_fetch_we", rf_we, 0);
        step();
        check("add_dec_ra", rf_ra, 0);
        check("add_dec_rb", rf_rb, 1);
        check("add_dec_aluop", alu_op, 0);
        step();
        check("add_exec_we", rf_we, 0);
        check("add_exec_retire", retire, 0);
        step();
        check("add_wb_we", rf_we, 1);
        check("add_wb_wa", rf_wa, 2);
        check("add_wb_retire", retire, 1);
        check("add_wb_pc", pc, 0);
        step();
        check("add_after_pc", pc, 1);
        check("add_after_we", rf_we, 0);
        check("add_after_retire", retire, 0);

        // SUB at pc 1; start held high while busy must be ignored
        start = 1'b1;
        step();
        check("sub_dec_ra", rf_ra, 3);
        check("sub_dec_rb", rf_rb, 2);
        check("sub_dec_aluop", alu_op, 1);
        start = 1'b0;
        step();
        check("sub_exec_pc", pc, 1);
        step();
        check("sub_wb_we", rf_we, 1);
        check("sub_wb_wa", rf_wa, 0);
        check("sub_wb_aluop", alu_op, 1);
        step();
        check("sub_after_pc", pc, 2);

        // BZ taken to 15
        rs_zero = 1'b1;
        step();
        check("bz_dec_ra", rf_ra, 0);
        step();
        check("bz_exec_retire", retire, 1);
        check("bz_exec_we", rf_we, 0);
        step();
        check("bz_taken_pc", pc, 15);
        check("bz_taken_we", rf_we, 0);
        rs_zero = 1'b0;

        // ADD at 15 wraps to 0
        step();
        step();
        step();
        check("wrap_wb_pc", pc, 15);
        check("wrap_wb_wa", rf_wa, 3);
        check("wrap_wb_we", rf_we, 1);
        step();
        check("wrap_pc", pc, 0);

        // Reset back to idle
        #2 rst = 1'b1;
        #1;
        check("rst2_pc", pc, 0);
        check("rst2_busy", busy, 0);
        step();
        rst = 1'b0;

        // Second run: BZ not taken, then HLT
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        check("r2_pc1", pc, 1);
        repeat (4) step();
        check("r2_pc2", pc, 2);
        step();
        step();
        check("bznt_exec_retire", retire, 1);
        step();
        check("bznt_pc", pc, 3);
        step();
        step();
        check("hlt_exec_retire", retire, 1);
        check("hlt_exec_halted", halted, 0);
        check("hlt_exec_busy", busy, 1);
        step();
        check("hlt_halted", halted, 1);
        check("hlt_busy", busy, 0);
        check("hlt_retire", retire, 0);
        for (int i = 0; i < 20; i++) begin
            step();
            check("hold_pc", pc, 3);
            check("hold_halted", halted, 1);
            check("hold_we", rf_we, 0);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        check("restart_pc", pc, 0);
        check("restart_busy", busy, 1);
        check("restart_halted", halted, 0);

        // Reset during WB of the ADD at pc 0
        step();
        step();
        step();
        check("mid_wb_we", rf_we, 1);
        check("mid_wb_retire", retire, 1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_we", rf_we, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_pc", pc, 0);
        check("mid_rst_retire", retire, 0);
        step();
        rst = 1'b0;
        step();
        check("post_rst_busy", busy, 0);
        check("post_rst_pc", pc, 0);
        check("post_rst_retire", retire, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle control sequencer for the 4-bit-PC / 8-bit-instruction simple CPU. Owns the program counter and instruction register, fetches from the asynchronous-read instruction memory, decodes the 2-bit opcode and steps the register file and ALU through fetch, decode, execute and write-back. Sits between the instruction memory, the register file and the ALU, and is the only block that writes the PC.

## Interface
- PC_W, 4, program counter and instruction memory address width
- INSTR_W, 8, instruction width; field layout is fixed for 8
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  level; sampled in IDLE or HALT; begins execution at PC 0
- imem_addr  out  PC_W  instruction memory address, always equal to pc
- imem_data  in  INSTR_W  instruction from memory, combinational on imem_addr
- rs_zero  in  1  register file port A read data == 0
- rf_ra  out  2  read address A = IR[5:4]
- rf_rb  out  2  read address B = IR[3:2]
- rf_wa  out  2  write address = IR[1:0]
- rf_we  out  1  register write enable, asserted in WB only
- alu_op  out  1  0 = add, 1 = subtract; equals IR[6]
- pc  out  PC_W  current program counter
- busy  out  1  high in FETCH, DECODE, EXEC and WB
- halted  out  1  high in HALT
- retire  out  1  one-cycle pulse when an instruction completes

## Operation
- Instruction fields: IR[7:6] opcode, IR[5:4] rs, IR[3:2] rt, IR[1:0] rd; branch target IR[3:0].
- Opcodes: 00 ADD REG[rd]=REG[rs]+REG[rt]; 01 SUB REG[rd]=REG[rs]-REG[rt]; 11 BZ: if REG[rs]==0 then pc=IR[3:0], else pc+1; 10 HLT.
- States: IDLE, FETCH, DECODE, EXEC, WB, HALT.
- IDLE: start=1 -> pc<=0, go to FETCH.
- FETCH: IR<=imem_data at clock edge; go to DECODE.
- DECODE: rf_ra and rf_rb are valid from IR; go to EXEC.
- EXEC, ADD/SUB: go to WB.
- EXEC, BZ: sample rs_zero; pc<=IR[3:0] if 1, else pc+1; pulse retire; go to FETCH.
- EXEC, HLT: pc unchanged; pulse retire; go to HALT.
- WB: rf_we=1, rf_wa=IR[1:0]; pc<=pc+1; pulse retire; go to FETCH.
- HALT: holds pc; start=1 -> pc<=0, go to FETCH.
- start is ignored while busy.
- pc increment is modulo 16: 1111+1 -> 0000, with no flag raised. A BZ taken to 1111 continues at 0000 after the next sequential instruction.
- rf_ra, rf_rb, rf_wa and alu_op are driven combinationally from IR in every state. Only rf_we qualifies a write.

## Timing
- Reset values: state IDLE, pc 0, IR 0, rf_we 0, retire 0, busy 0, halted 0. All outputs derived from IR are therefore 0.
- Reset asserted mid-instruction forces IDLE asynchronously. rf_we drops in the same cycle and no write completes.
- Latency from start sampled to first FETCH: 1 cycle.
- ADD and SUB take 4 cycles: FETCH, DECODE, EXEC, WB.
- BZ and HLT take 3 cycles: FETCH, DECODE, EXEC.
- The register file writes on the clk edge that ends WB. The next FETCH sees the updated pc.
- rs_zero must be stable from DECODE through EXEC. It is sampled only at the EXEC edge of a BZ.
- retire is registered-free: it is a combinational function of state and IR, high exactly one cycle per instruction.

## Structure
- Shared package / include cpu_defs: opcode localparams OP_ADD=2'b00, OP_SUB=2'b01, OP_HLT=2'b10, OP_BZ=2'b11; state encodings; field bit positions. The register file and ALU reuse these.
- One sub-module: cpu_pc_counter, a 4-bit register with clear, load(target) and increment (wrapping). It has asynchronous active-high reset.
- The FSM, IR and output decode live in cpu_sequencer.

## Test plan
- Reset then idle: rst pulse, start=0 for 10 cycles -> pc=0, busy=0, rf_we never 1, imem_addr=0.
- ADD: memory[0]=8'b00000110, start=1 -> FETCH at cycle 1, rf_we=1 in cycle 4 with rf_wa=2, alu_op=0, rf_ra=0, rf_rb=1; pc=1 after; retire once.
- SUB then BZ taken: memory[1]=8'b01111000, memory[2]=8'b11001111, rs_zero=1 during BZ EXEC -> SUB writes rf_wa=0 with alu_op=1; after BZ, pc=15, with no rf_we during BZ.
- BZ not taken and wrap: same program with rs_zero=0 -> pc=3. Then, with memory[15]=ADD and a BZ taken to 15 -> pc goes 15 -> 0 after WB.
- HLT and restart: memory[3]=8'b10000000 -> halted=1, pc=3 held for 20 cycles. start=1 -> pc=0, busy=1 on the next cycle.
- Reset mid-WB: assert rst during WB of an ADD -> rf_we=0 in the same cycle, state IDLE, pc=0, no retire pulse.
